// File: rtl/rsqrt_seed_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsqrt_seed_pkg
// Description : Shared constants and elaboration-time helpers for rsqrt_seed.
// Revision    : 1.0 - initial release
// ============================================================================
package rsqrt_seed_pkg;

  localparam int LATENCY = 3;

  // Entry = round-nearest(2^qw / sqrt(mid)), solved exactly in integers as
  // the largest y with (2y-1)^2 * mid_num * k <= 4 * 2^(2qw+lut_bits).
  function automatic longint unsigned rsqrt_lut_entry(input int qw, input int lut_bits,
                                                      input int idx);
    longint unsigned half;
    longint unsigned f;
    longint unsigned k;
    longint unsigned num;
    longint unsigned bound;
    longint unsigned y;
    longint unsigned cand;
    longint unsigned t;
    half  = longint'(1) << (lut_bits - 1);
    f     = longint'(idx) & (half - 1);
    k     = ((longint'(idx) >> (lut_bits - 1)) & 1) != 0 ? 2 : 1;
    num   = 2 * half + 2 * f + 1;
    bound = longint'(4) << (2 * qw + lut_bits);
    y     = 0;
    for (int b = qw + 1; b >= 0; b--) begin
      cand = y | (longint'(1) << b);
      t    = 2 * cand - 1;
      if (t * t * num * k <= bound) y = cand;
    end
    return y;
  endfunction

  function automatic longint unsigned sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rsqrt_seed_lzc.sv
`default_nettype none
// ============================================================================
// Module      : rsqrt_seed_lzc
// Description : Combinational leading-one position and all-zero detect.
// Revision    : 1.0 - initial release
// ============================================================================
module rsqrt_seed_lzc #(
  parameter int W  = 16,
  parameter int PW = $clog2(W)
) (
  input  logic [W-1:0]  i_data,
  output logic [PW-1:0] o_pos,
  output logic          o_zero
);

  always_comb begin
    o_pos = '0;
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) o_pos = PW'(i);
    end
  end

  assign o_zero = (i_data == '0);

endmodule
`default_nettype wire

// File: rtl/rsqrt_seed.sv
`default_nettype none
// ============================================================================
// Module      : rsqrt_seed
// Description : 3-stage pipelined 1/sqrt(S) seed generator for Goldschmidt.
// Revision    : 1.0 - initial release
// ============================================================================
module rsqrt_seed
  import rsqrt_seed_pkg::*;
#(
  parameter int IW       = 8,
  parameter int QW       = 8,
  parameter int LUT_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [IW+QW-1:0]     in,
  output logic [IW+QW-1:0]     est,
  output logic [IW+QW-1:0]     s_out,
  output logic                 valid,
  output logic                 invalid
);

  localparam int W    = IW + QW;
  localparam int PW   = $clog2(W);
  localparam int JW   = PW + 2;
  localparam int FB   = LUT_BITS - 1;
  localparam int NLUT = 2 ** LUT_BITS;

  localparam logic [W-1:0] c_sat_max = W'(sat_max(W));

  logic [W-1:0] w_lut [NLUT];

  for (genvar gi = 0; gi < NLUT; gi++) begin : g_lut
    assign w_lut[gi] = W'(rsqrt_lut_entry(QW, LUT_BITS, gi));
  end

  // ---------------------------------------------------------------- stage 1
  logic [PW-1:0] w_pos;
  logic          w_zero;

  rsqrt_seed_lzc #(
    .W  (W),
    .PW (PW)
  ) u_lzc (
    .i_data (in),
    .o_pos  (w_pos),
    .o_zero (w_zero)
  );

  logic          r_v1;
  logic [W-1:0]  r_s1;
  logic [PW-1:0] r_p1;
  logic          r_zero1;
  logic          r_neg1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1    <= 1'b0;
      r_s1    <= '0;
      r_p1    <= '0;
      r_zero1 <= 1'b0;
      r_neg1  <= 1'b0;
    end else begin
      r_v1 <= start;
      if (start) begin
        r_s1    <= in;
        r_p1    <= w_pos;
        r_zero1 <= w_zero;
        r_neg1  <= in[W-1];
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic signed [JW-1:0] w_e;
  logic signed [JW-1:0] w_j;
  logic [PW-1:0]        w_nsh;
  logic [FB-1:0]        w_f;
  logic [LUT_BITS-1:0]  w_idx;

  assign w_e   = $signed(JW'(r_p1)) - $signed(JW'(QW));
  assign w_j   = w_e >>> 1;
  assign w_nsh = PW'(W - 1) - r_p1;
  // Normalise so the leading one sits at W-1, then keep the FB bits below it.
  assign w_f   = FB'((r_s1 << w_nsh) >> (W - 1 - FB));
  assign w_idx = {w_e[0], w_f};

  logic                 r_v2;
  logic [W-1:0]         r_s2;
  logic signed [JW-1:0] r_j2;
  logic [W-1:0]         r_lut2;
  logic                 r_zero2;
  logic                 r_neg2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v2    <= 1'b0;
      r_s2    <= '0;
      r_j2    <= '0;
      r_lut2  <= '0;
      r_zero2 <= 1'b0;
      r_neg2  <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_s2    <= r_s1;
        r_j2    <= w_j;
        r_lut2  <= w_lut[w_idx];
        r_zero2 <= r_zero1;
        r_neg2  <= r_neg1;
      end
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic [JW-1:0]  w_nj;
  logic [2*W-1:0] w_wide;
  logic [W-1:0]   w_den;
  logic [W-1:0]   w_est;
  logic           w_inv;

  assign w_nj   = JW'(-r_j2);
  assign w_wide = {{W{1'b0}}, r_lut2} << w_nj;

  always_comb begin
    w_den = '0;
    if (!r_j2[JW-1]) begin
      w_den = r_lut2 >> $unsigned(r_j2);
    end else if ((int'(w_nj) >= W && r_lut2 != '0) || (|w_wide[2*W-1:W-1])) begin
      w_den = c_sat_max;
    end else begin
      w_den = w_wide[W-1:0];
    end
  end

  always_comb begin
    w_est = w_den;
    w_inv = 1'b0;
    if (r_zero2) begin
      w_est = c_sat_max;
      w_inv = 1'b1;
    end else if (r_neg2) begin
      w_est = '0;
      w_inv = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      est     <= '0;
      s_out   <= '0;
      invalid <= 1'b0;
    end else begin
      valid <= r_v2;
      if (r_v2) begin
        est     <= w_est;
        s_out   <= r_s2;
        invalid <= w_inv;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rsqrt_seed.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsqrt_seed
// Description : Directed scoreboard bench for rsqrt_seed (IW=8, QW=8, LUT_BITS=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsqrt_seed;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] in;
  logic [15:0] est;
  logic [15:0] s_out;
  logic        valid;
  logic        invalid;

  int n_checks;
  int n_fail;
  int cyc;

  typedef struct {
    logic [15:0] s;
    logic [15:0] e;
    logic        inv;
    int          due;
  } exp_t;

  exp_t q[$];

  rsqrt_seed #(
    .IW       (8),
    .QW       (8),
    .LUT_BITS (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .in      (in),
    .est     (est),
    .s_out   (s_out),
    .valid   (valid),
    .invalid (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per valid output and compares.
  always @(negedge clk) begin
    if (!reset && valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got est=0x%0h s_out=0x%0h expected no output", est, s_out);
      end else begin
        exp_t x;
        x = q.pop_front();
        check("est", 32'(est), 32'(x.e));
        check("s_out", 32'(s_out), 32'(x.s));
        check("invalid", 32'(invalid), 32'(x.inv));
        check("latency_cycle", 32'(cyc), 32'(x.due));
      end
    end
  end

  task automatic issue(input logic [15:0] s, input logic [15:0] e, input logic inv,
                       input bit track);
    exp_t x;
    @(negedge clk);
    start = 1'b1;
    in    = s;
    if (track) begin
      x.s   = s;
      x.e   = e;
      x.inv = inv;
      x.due = cyc + 3;
      q.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
      in    = 16'h0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b1;
    in       = 16'h0100;
    repeat (3) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_est", 32'(est), 32'h0);
    check("reset_s_out", 32'(s_out), 32'h0);
    check("reset_invalid", 32'(invalid), 32'h0);
    reset = 1'b0;
    idle(2);

    // Isolated operands
    issue(16'h0100, 16'h00F8, 1'b0, 1'b1); idle(4);
    issue(16'h0200, 16'h00B0, 1'b0, 1'b1); idle(4);
    issue(16'h0400, 16'h007C, 1'b0, 1'b1); idle(4);
    issue(16'h0040, 16'h01F0, 1'b0, 1'b1); idle(4);
    issue(16'h0001, 16'h0F80, 1'b0, 1'b1); idle(4);
    issue(16'h0000, 16'h7FFF, 1'b1, 1'b1); idle(4);
    issue(16'h8000, 16'h0000, 1'b1, 1'b1); idle(4);

    // Back-to-back, no bubbles
    issue(16'h0100, 16'h00F8, 1'b0, 1'b1);
    issue(16'h0200, 16'h00B0, 1'b0, 1'b1);
    issue(16'h0400, 16'h007C, 1'b0, 1'b1);
    issue(16'h7FFF, 16'h0017, 1'b0, 1'b1);
    issue(16'h0003, 16'h0910, 1'b0, 1'b1);
    issue(16'hFFFF, 16'h0000, 1'b1, 1'b1);
    idle(6);

    // Reset one cycle after a start discards the operand
    issue(16'h0100, 16'h00F8, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(5);
    issue(16'h0200, 16'h00B0, 1'b0, 1'b1);
    idle(1);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", q.size());
    end
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
